fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_W, default 8: program-counter width in bits; PC arithmetic is modulo 2^PC_W.
REQ-002 Parameter INS_W, default 32: instruction width in bits.
REQ-003 Parameter QDEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port imem_addr, output, PC_W: current fetch PC, driven straight from the PC register.
REQ-008 Port imem_data, input, INS_W: instruction at imem_addr; combinational, valid in the same cycle.
REQ-009 Port redirect_valid, input, 1: branch/jump redirect request.
REQ-010 Port redirect_pc, input, PC_W: redirect target; sampled when redirect_valid=1.
REQ-011 Port out_valid, output, 1: queue head holds an instruction.
REQ-012 Port out_ready, input, 1: consumer accepts the head this cycle.
REQ-013 Port out_ins, output, INS_W: head instruction.
REQ-014 Port out_pc, output, PC_W: PC of the head instruction.
REQ-015 Port q_count, output, $clog2(QDEPTH+1): current queue occupancy.

Function
REQ-016 A pop occurs in a cycle when out_valid=1 and out_ready=1; out_valid SHALL equal (q_count != 0), decoded from registered state only.
REQ-017 A push occurs in a cycle when redirect_valid=0 and either q_count < QDEPTH or a pop occurs in the same cycle; the push enqueues {imem_addr, imem_data}.
REQ-018 On a push, the PC SHALL advance to PC+1 (wrapping from 2^PC_W-1 to 0); otherwise the PC holds.
REQ-019 When the queue is full and no pop occurs, the PC and the queue SHALL hold; no entry is dropped or duplicated.
REQ-020 A simultaneous push and pop SHALL leave q_count unchanged.
REQ-021 Queue ordering is strict FIFO; out_ins and out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 Latency: an instruction fetched at an edge SHALL be presented on the out_* ports starting in the cycle after that edge.
REQ-023 When redirect_valid=1, at the next edge the queue is flushed (q_count=0), PC is loaded with redirect_pc, and no push occurs; this takes priority over push, full and pop.
REQ-024 A pop handshake in a redirect cycle counts as consumed; discarding that instruction is the consumer's responsibility.
REQ-025 Read/write pointers SHALL be log2(QDEPTH) bits wide and wrap naturally; occupancy is tracked by a separate counter.

Reset
REQ-026 While rst=0, asynchronously: PC=RESET_PC, q_count=0, pointers=0, out_valid=0.
REQ-027 out_ins and out_pc are don't-care while out_valid=0; storage array entries are not reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries with no partial state retained.
REQ-029 The first push SHALL occur at the first rising edge with rst=1.

Structure
REQ-030 The defaults for PC_W and INS_W, and the NOP encoding, SHALL live in the shared CPU package used by the fetch and decode stages.
REQ-031 The queue SHALL be implemented as one sub-module, fetch_fifo, parameterised by width (PC_W+INS_W) and QDEPTH, with push/pop/flush/count ports.
REQ-032 The PC register and the push/redirect control SHALL live in fetch_stage.

Verification
Benches use PC_W=8 and QDEPTH=4, with a memory model returning imem_data = {24'h0, imem_addr}.
REQ-033 Reset release, out_ready=1 throughout -> out_valid from the first edge; out_pc sequence 0,1,2,3,...; out_ins = out_pc; q_count stays 1.
REQ-034 out_ready=0 for 6 cycles after reset -> q_count 1,2,3,4,4,4; imem_addr holds at 4; then out_ready=1 -> out_pc 0,1,2,3,4,5 with no gap or repeat.
REQ-035 Redirect to 8'h40 with q_count=3 and out_ready=0 -> next cycle q_count=0, out_valid=0, imem_addr=8'h40; the cycle after, out_pc=8'h40.
REQ-036 Redirect to 8'hFE, out_ready=1 -> out_pc FE, FF, 00, 01 (wrap-around).
REQ-037 Queue full and out_ready=0 with redirect to 8'h10 in the same cycle -> flush wins: q_count=0, then out_pc=8'h10.
REQ-038 rst driven low between clock edges with q_count=2 -> immediately out_valid=0, q_count=0, imem_addr=RESET_PC; fetching resumes from 0 after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch and decode stages.
package fetch_stage_pkg;
  localparam int PC_W_DEF  = 8;
  localparam int INS_W_DEF = 32;
  // addi x0, x0, 0
  localparam logic [INS_W_DEF-1:0] NOP_INS = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_fifo.sv
// Fetch queue: power-of-two ring buffer with a separate occupancy counter and a flush.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = PC_W_DEF + INS_W_DEF,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; stale entries are never visible because count gates them.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, push/redirect control and a decoupling fetch queue.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int          INS_W    = INS_W_DEF,
  parameter int          QDEPTH   = 4,
  parameter int unsigned RESET_PC = 0,
  localparam int         CW       = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_data,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  output logic [CW-1:0]    q_count
);

  localparam int EW = PC_W + INS_W;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            pop, push, full;
  logic [EW-1:0]   head;

  assign full      = (q_count == CW'(QDEPTH));
  assign out_valid = (q_count != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign push      = !redirect_valid && (!full || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= PC_W'(RESET_PC);
    else      pc_q <= pc_d;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, imem_data}),
    .rdata (head),
    .count (q_count)
  );

  assign imem_addr = pc_q;
  assign out_pc    = head[EW-1:INS_W];
  assign out_ins   = head[INS_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a queue-based behavioural model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [7:0]  out_pc;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] ins;
  } ent_t;
  ent_t       mq[$];
  logic [7:0] mpc;

  typedef struct {
    logic       rdy;
    logic [2:0] cnt;
    logic [7:0] addr;
    logic [7:0] opc;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;
  assign imem_data = {24'h0, imem_addr};

  fetch_stage #(
    .PC_W     (8),
    .INS_W    (32),
    .QDEPTH   (4),
    .RESET_PC (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .q_count        (q_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 8'h00;
  endtask

  // Cycle-level rules: redirect flushes and reloads PC; otherwise pop the head if
  // consumed, then fetch the current PC whenever a slot is free.
  task automatic model_step(input logic rv, input logic [7:0] rpc, input logic rdy);
    ent_t e;
    if (rv) begin
      mq.delete();
      mpc = rpc;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (mq.size() < 4) begin
        e.pc  = mpc;
        e.ins = {24'h0, mpc};
        mq.push_back(e);
        mpc = mpc + 8'd1;
      end
    end
  endtask

  task automatic model_check();
    chk("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_count", 32'(q_count), 32'(mq.size()));
    chk("m_addr", 32'(imem_addr), 32'(mpc));
    if (mq.size() != 0) begin
      chk("m_out_pc", 32'(out_pc), 32'(mq[0].pc));
      chk("m_out_ins", out_ins, mq[0].ins);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic cycle(input logic rv, input logic [7:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 3'd1, 8'd1,  8'd0};
    tbl[1]  = '{1'b0, 3'd2, 8'd2,  8'd0};
    tbl[2]  = '{1'b0, 3'd3, 8'd3,  8'd0};
    tbl[3]  = '{1'b0, 3'd4, 8'd4,  8'd0};
    tbl[4]  = '{1'b0, 3'd4, 8'd4,  8'd0};
    tbl[5]  = '{1'b0, 3'd4, 8'd4,  8'd0};
    tbl[6]  = '{1'b1, 3'd4, 8'd5,  8'd1};
    tbl[7]  = '{1'b1, 3'd4, 8'd6,  8'd2};
    tbl[8]  = '{1'b1, 3'd4, 8'd7,  8'd3};
    tbl[9]  = '{1'b1, 3'd4, 8'd8,  8'd4};
    tbl[10] = '{1'b1, 3'd4, 8'd9,  8'd5};
    tbl[11] = '{1'b1, 3'd4, 8'd10, 8'd6};

    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    rst = 1'b1;

    // Streaming with the consumer always ready
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_count", 32'(q_count), 32'd1);
      chk("stream_pc", 32'(out_pc), 32'(i));
      chk("stream_ins", out_ins, 32'(i));
    end

    // Asynchronous reset between edges with two entries queued
    cycle(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(q_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_count", 32'(q_count), 32'd0);
    chk("async_addr", 32'(imem_addr), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Backpressure then drain, from a fresh reset
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 8'h00, tbl[i].rdy);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_count", 32'(q_count), 32'(tbl[i].cnt));
      chk("tbl_addr", 32'(imem_addr), 32'(tbl[i].addr));
      chk("tbl_out_pc", 32'(out_pc), 32'(tbl[i].opc));
    end

    // Redirect with a partly filled queue and a stalled consumer
    cycle(1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("part_count", 32'(q_count), 32'd3);
    cycle(1'b1, 8'h40, 1'b0);
    chk("redir_count", 32'(q_count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    cycle(1'b0, 8'h00, 1'b0);
    chk("redir_out_pc", 32'(out_pc), 32'h40);

    // Redirect while full and stalled: flush wins
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("full_count", 32'(q_count), 32'd4);
    chk("full_addr", 32'(imem_addr), 32'h44);
    cycle(1'b1, 8'h10, 1'b0);
    chk("flush_count", 32'(q_count), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("flush_out_pc", 32'(out_pc), 32'h10);

    // PC wrap-around
    cycle(1'b1, 8'hFE, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("wrap_pc0", 32'(out_pc), 32'hFE);
    cycle(1'b0, 8'h00, 1'b1);
    chk("wrap_pc1", 32'(out_pc), 32'hFF);
    cycle(1'b0, 8'h00, 1'b1);
    chk("wrap_pc2", 32'(out_pc), 32'h00);
    cycle(1'b0, 8'h00, 1'b1);
    chk("wrap_pc3", 32'(out_pc), 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 11) == 0), 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
